// File: rtl/fsub_seq_if.sv
// Handshake and operand/result bundle for the iterative single-precision subtractor.
// The controller side drives start/a/b and watches busy/done/y.
interface fsub_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;

  modport master (output start, a, b, input busy, done, y);
  modport slave  (input start, a, b, output busy, done, y);
endinterface

// File: rtl/fsub_seq.sv
// Iterative IEEE-754 single-precision y = a - b, truncating; alignment and
// normalization each move one bit per clock over a 27-bit hidden/fraction/G/R/S datapath.
module fsub_seq (
  input  logic      clk,
  input  logic      rst_n,
  fsub_seq_if.slave bus
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, PACK} state_t;
  state_t state, state_nx;

  logic [31:0]       a_r, b_r;
  logic              sx, eff_sub, spec;
  logic [31:0]       spec_val;
  logic signed [9:0] ex;
  logic [26:0]       mx, my;
  logic [4:0]        cnt;

  logic              sa, sb, a_big, up_special;
  logic [7:0]        ea, eb, ex_u, ey_u, ediff;
  logic [22:0]       fa, fb, fx, fy;
  logic [4:0]        up_d;
  logic [31:0]       up_val;
  logic [27:0]       sum;
  logic [26:0]       nrm_m;
  logic signed [9:0] nrm_e;

  // Right shift by one with the dropped bit folded into sticky.
  function automatic logic [26:0] shr_sticky(input logic [27:0] v);
    return {v[27:2], v[1] | v[0]};
  endfunction

  // Exponent saturation to infinity; truncation simply drops G/R/S.
  function automatic logic [31:0] pack_result(input logic s, input logic signed [9:0] e,
                                              input logic [22:0] f);
    if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
    return {s, e[7:0], f};
  endfunction

  assign sa = a_r[31];
  assign sb = ~b_r[31];
  assign ea = a_r[30:23];
  assign eb = b_r[30:23];
  assign fa = a_r[22:0];
  assign fb = b_r[22:0];

  assign a_big = (a_r[30:0] >= b_r[30:0]);
  assign ex_u  = a_big ? ea : eb;
  assign ey_u  = a_big ? eb : ea;
  assign fx    = a_big ? fa : fb;
  assign fy    = a_big ? fb : fa;
  assign ediff = ex_u - ey_u;
  assign up_d  = (ediff > 8'd26) ? 5'd26 : ediff[4:0];

  always_comb begin
    up_special = 1'b1;
    up_val     = QNAN;
    if ((ea == 8'hFF && fa != 23'h0) || (eb == 8'hFF && fb != 23'h0))
      up_val = QNAN;
    else if (ea == 8'hFF && eb == 8'hFF)
      up_val = (sa == sb) ? {sa, 8'hFF, 23'h0} : QNAN;
    else if (ea == 8'hFF)
      up_val = {sa, 8'hFF, 23'h0};
    else if (eb == 8'hFF)
      up_val = {sb, 8'hFF, 23'h0};
    else if (ea == 8'h00 && eb == 8'h00)
      up_val = {sa & sb, 31'h0};
    else if (ea == 8'h00)
      up_val = {sb, b_r[30:0]};
    else if (eb == 8'h00)
      up_val = a_r;
    else
      up_special = 1'b0;
  end

  // X >= Y in magnitude, so the subtraction never borrows out of bit 27.
  assign sum   = eff_sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
  assign nrm_m = {mx[25:0], 1'b0};
  assign nrm_e = ex - 10'sd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (bus.start) state_nx = UNPACK;
      UNPACK: begin
        if (up_special)       state_nx = PACK;
        else if (up_d == 5'd0) state_nx = ADD;
        else                  state_nx = ALIGN;
      end
      ALIGN:  if (cnt == 5'd1) state_nx = ADD;
      ADD: begin
        if (sum == 28'd0 || sum[27] || sum[26]) state_nx = PACK;
        else                                    state_nx = NORM;
      end
      NORM:   if (nrm_e <= 10'sd0 || nrm_m[26]) state_nx = PACK;
      PACK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.y    <= 32'h0;
    end else begin
      bus.done <= (state == PACK);
      if (state == IDLE && bus.start) bus.busy <= 1'b1;
      else if (state == PACK)         bus.busy <= 1'b0;
      if (state == PACK)
        bus.y <= spec ? spec_val : pack_result(sx, ex, mx[25:3]);
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (bus.start) begin
        a_r <= bus.a;
        b_r <= bus.b;
      end
      UNPACK: begin
        spec     <= up_special;
        spec_val <= up_val;
        sx       <= a_big ? sa : sb;
        eff_sub  <= (sa != sb);
        ex       <= $signed({2'b00, ex_u});
        mx       <= {1'b1, fx, 3'b000};
        my       <= {1'b1, fy, 3'b000};
        cnt      <= up_d;
      end
      ALIGN: begin
        my  <= shr_sticky({1'b0, my});
        cnt <= cnt - 5'd1;
      end
      ADD: begin
        if (sum == 28'd0) begin
          spec     <= 1'b1;
          spec_val <= 32'h0;
        end else if (sum[27]) begin
          mx <= shr_sticky(sum);
          ex <= ex + 10'sd1;
        end else begin
          mx <= sum[26:0];
        end
      end
      NORM: begin
        mx <= nrm_m;
        ex <= nrm_e;
        if (nrm_e <= 10'sd0) begin
          spec     <= 1'b1;
          spec_val <= {sx, 31'h0};
        end
      end
      default: ;
    endcase
  end
endmodule
